// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_loader_pkg;

  localparam int unsigned LANES  = 6;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } state_e;

endpackage

// File: rtl/lane_assembler.sv
// Packs a byte stream into one instruction word, lane 0 in the least significant byte.
module lane_assembler #(
  parameter int unsigned LANES  = 6,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic [BYTE_W-1:0]         i_byte,
  output logic [LANES*BYTE_W-1:0]   o_word,
  output logic                      o_last
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]        r_idx;
  logic [LANES*BYTE_W-1:0] r_word;
  logic                    w_last;

  assign w_last = (r_idx == IDX_W'(LANES - 1));
  assign o_last = w_last;
  assign o_word = r_word;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_load) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_idx == IDX_W'(k)) begin
          r_word[k*BYTE_W +: BYTE_W] <= i_byte;
        end
      end
      // Wrap after the last lane so the next word starts at lane 0.
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into program memory as LANES-byte words with a running checksum.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LANES      = prog_loader_pkg::LANES
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [ADDR_WIDTH-1:0]   i_word_count,
  input  logic                    i_abort,
  input  logic                    i_in_valid,
  input  logic [7:0]              i_in_data,
  output logic                    o_in_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [8*LANES-1:0]      o_mem_data,
  output logic                    o_mem_we_n,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [7:0]              o_checksum
);

  import prog_loader_pkg::*;

  state_e                  r_state;
  state_e                  w_state_d;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_remain;
  logic [BYTE_W-1:0]       r_checksum;

  logic                    w_accept;
  logic                    w_clear;
  logic                    w_load_ctrs;
  logic                    w_write;
  logic                    w_last;
  logic [8*LANES-1:0]      w_word;

  lane_assembler #(
    .LANES  (LANES),
    .BYTE_W (BYTE_W)
  ) u_lane_assembler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_clear),
    .i_load    (w_accept),
    .i_byte    (i_in_data),
    .o_word    (w_word),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    w_load_ctrs = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        // Abort takes priority over a simultaneous start.
        if (i_start && !i_abort) begin
          w_clear     = 1'b1;
          w_load_ctrs = 1'b1;
          w_state_d   = (i_word_count == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        if (i_abort) begin
          w_clear   = 1'b1;
          w_state_d = IDLE;
        end else if (i_in_valid) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (i_abort) begin
          w_clear   = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_write   = 1'b1;
          w_state_d = (r_remain == ADDR_WIDTH'(1)) ? FINISH : COLLECT;
        end
      end
      FINISH: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_load_ctrs) begin
      r_addr   <= i_base_addr;
      r_remain <= i_word_count;
    end else if (w_write) begin
      r_addr   <= r_addr + 1'b1;
      r_remain <= r_remain - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_checksum <= '0;
    end else if (w_load_ctrs) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + i_in_data;
    end
  end

  assign o_in_ready = (r_state == COLLECT) && !i_abort;
  assign o_mem_we_n = !w_write;
  assign o_mem_addr = r_addr;
  assign o_mem_data = w_word;
  assign o_busy     = (r_state == COLLECT) || (r_state == WRITE);
  assign o_done     = (r_state == FINISH);
  assign o_checksum = r_checksum;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes/done, a monitor pops and checks.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [47:0] mem_data;
  logic        mem_we_n;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  prog_loader #(
    .ADDR_WIDTH (16),
    .LANES      (6)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_word_count (word_count),
    .i_abort      (abort),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_we_n   (mem_we_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_checksum   (checksum)
  );

  typedef struct {
    logic [15:0] addr;
    logic [47:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] cs;
    int         cyc;
  } done_t;

  wr_t        exp_wr[$];
  done_t      exp_done[$];
  logic [7:0] src_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_we_n) begin
        check("in_ready_in_write", {63'd0, in_ready}, 64'd0);
        if (exp_wr.size() == 0) begin
          flag("unexpected_write");
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", {48'd0, mem_addr}, {48'd0, e.addr});
          check("wr_data", {16'd0, mem_data}, {16'd0, e.data});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          flag("unexpected_done");
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("checksum", {56'd0, checksum}, {56'd0, d.cs});
          check("wr_queue_empty_at_done", 64'(exp_wr.size()), 64'd0);
          if (d.cyc >= 0) check("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_mem_we_n"}, {63'd0, mem_we_n}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_checksum"}, {56'd0, checksum}, 64'd0);
    check({tag, "_mem_addr"}, {48'd0, mem_addr}, 64'd0);
    check({tag, "_mem_data"}, {16'd0, mem_data}, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    step();
    start      = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle (with ignored start), 2: random valid.
  task automatic feed(input int mode);
    int   idx = 0;
    int   guard = 0;
    bit   ph = 1'b1;
    logic acc;
    while (idx < src_q.size() && guard < 2000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = ph; ph = !ph; end
        default: in_valid = ($urandom_range(3) != 0);
      endcase
      start     = (mode == 1);
      base_addr = 16'(idx * 16'h0101);
      in_data   = src_q[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (guard >= 2000) flag("feed_timeout");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      flag("done_timeout");
      exp_wr.delete();
      exp_done.delete();
    end
    step();
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  // Reference: word w = bytes 6w..6w+5 little endian at base+w (mod 2^16); checksum = sum mod 256.
  task automatic load(input logic [15:0] b, input logic [15:0] n, input int mode, input bit directed);
    int    sum = 0;
    done_t d;
    src_q.delete();
    for (int i = 0; i < int'(n) * 6; i++) begin
      src_q.push_back(directed ? 8'(i + 1) : 8'($urandom_range(255)));
    end
    if (directed) begin
      exp_wr.push_back('{addr: 16'h0400, data: 48'h060504030201});
      exp_wr.push_back('{addr: 16'h0401, data: 48'h0C0B0A090807});
      d.cs = 8'h4E;
    end else begin
      for (int w = 0; w < int'(n); w++) begin
        wr_t e;
        e.addr = 16'(int'(b) + w);
        e.data = '0;
        for (int k = 0; k < 6; k++) e.data = e.data | (48'(src_q[w*6 + k]) << (8 * k));
        exp_wr.push_back(e);
      end
      foreach (src_q[i]) sum += int'(src_q[i]);
      d.cs = 8'(sum % 256);
    end
    d.cyc = (mode == 0) ? cyc + 7 * int'(n) + 1 : -1;
    exp_done.push_back(d);
    do_start(b, n);
    feed(mode);
    wait_idle(3000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    chk_reset_vals("por");
    rst_n = 1'b1;
    step();

    load(16'h0400, 16'd2, 0, 1'b1);
    load(16'h0400, 16'd2, 1, 1'b1);
    load(16'hFFFF, 16'd2, 0, 1'b0);
    load(16'h1234, 16'd0, 0, 1'b0);

    // Start and abort together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1; base_addr = 16'h0010; word_count = 16'd1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", {63'd0, busy}, 64'd0);

    // Abort after three bytes of the first word.
    do_start(16'h1000, 16'd2);
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(8'(8'hA0 + i));
    feed(0);
    abort = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    repeat (20) step();
    load(16'h0400, 16'd2, 0, 1'b1);

    // Reset asserted while the first word's write strobe is active.
    do_start(16'h2000, 16'd2);
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom_range(255)));
    feed(0);
    check("write_cycle_we", {63'd0, mem_we_n}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_write");
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("post_reset_busy", {63'd0, busy}, 64'd0);

    for (int t = 0; t < 8; t++) begin
      logic [15:0] b;
      b = ($urandom_range(1) == 0) ? 16'($urandom) : 16'(16'hFFFD + $urandom_range(2));
      load(b, 16'($urandom_range(3)), int'($urandom_range(2)), 1'b0);
    end

    repeat (5) step();
    check("final_wr_queue", 64'(exp_wr.size()), 64'd0);
    check("final_done_queue", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, program-memory address width.
REQ-002 Parameter LANES, default 6, bytes per instruction word; word width = 8*LANES = 48.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 _reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin load; samples base_addr and word_count.
REQ-006 base_addr  input  ADDR_WIDTH  first program-memory address written.
REQ-007 word_count  input  ADDR_WIDTH  number of 48-bit words to load.
REQ-008 abort  input  1  cancel load in progress.
REQ-009 in_valid  input  1  in_data holds a byte.
REQ-010 in_data  input  8  image byte stream, lane 0 first (little endian per word).
REQ-011 in_ready  output  1  loader accepts byte this cycle.
REQ-012 mem_addr  output  ADDR_WIDTH  program-memory write address.
REQ-013 mem_data  output  48  assembled instruction word.
REQ-014 _mem_we  output  1  program-memory write strobe, active-low.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 checksum  output  8  sum mod 256 of all bytes accepted since last start.

Function
REQ-018 FSM states IDLE, COLLECT, WRITE, FINISH; busy=1 in COLLECT and WRITE only.
REQ-019 IDLE: start=1 latches base_addr into address counter, word_count into remaining count, clears checksum and lane index; next COLLECT, or FINISH if word_count=0.
REQ-020 COLLECT: in_ready=1; byte accepted when in_valid&&in_ready; byte k (k=0..5) stored to bits [8k+7:8k]; checksum += byte (8-bit wrap).
REQ-021 On acceptance of lane 5, next state WRITE; in_valid=0 stalls COLLECT indefinitely with no state change.
REQ-022 WRITE: in_ready=0; _mem_we=0 for exactly one cycle with mem_addr=counter, mem_data=assembled word; then counter+1, remaining-1.
REQ-023 After WRITE: remaining=0 -> FINISH, else COLLECT with lane index 0.
REQ-024 FINISH: done=1 for one cycle, next IDLE; checksum held until next start.
REQ-025 Minimum throughput 7 cycles/word (6 accept + 1 write).
REQ-026 Address counter wraps 2^ADDR_WIDTH-1 -> 0 without error.
REQ-027 start while busy ignored; start and abort together in IDLE: abort wins, stays IDLE.
REQ-028 abort in COLLECT/WRITE: next state IDLE, partial word discarded, no write issued in that cycle, done not pulsed; abort in WRITE suppresses _mem_we.
REQ-029 mem_addr/mem_data stable whenever _mem_we=0; _mem_we=1 in all states other than WRITE.

Reset
REQ-030 _reset=0 forces immediately: state IDLE, in_ready=0, _mem_we=1, busy=0, done=0, checksum=0, mem_addr=0, mem_data=0, counters 0.
REQ-031 Reset mid-load discards partial word; no write strobe glitch on assertion or release.

Structure
REQ-032 Shared package prog_loader_pkg holds state enum (IDLE, COLLECT, WRITE, FINISH), LANES=6, BYTE_W=8, WORD_W=48.
REQ-033 One sub-module lane_assembler: lane index counter plus 48-bit byte-lane register with clear, load-byte and last-lane output.

Verification
REQ-034 start, base_addr=0x0400, word_count=2, bytes 0x01..0x0C back-to-back -> writes [0x0400]=0x060504030201, [0x0401]=0x0C0B0A090807, checksum=0x4E, done 15 cycles after start.
REQ-035 Same load with in_valid toggling every other cycle -> identical writes and checksum, in_ready never high in WRITE.
REQ-036 base_addr=0xFFFF, word_count=2 -> writes at 0xFFFF then 0x0000, done pulses once.
REQ-037 word_count=0 -> no _mem_we pulse, done one cycle after start, checksum=0.
REQ-038 abort after 3 bytes of word 1 -> no write, busy=0 next cycle, done never asserted; restart loads correctly.
REQ-039 _reset asserted during WRITE -> _mem_we high immediately, all outputs at reset values, no further writes.
